// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// variable-latency memory handshake, multi-cycle MULT/DIV stall and sticky traps.
module multicycle_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter bit BIG_ENDIAN  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic [1:0] i_addr_lo,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic [3:0] o_mem_we,
    output logic       o_ir_we,
    output logic       o_pc_we,
    output logic       o_regwrite,
    output logic       o_regdst,
    output logic       o_alusrc,
    output logic       o_memtoreg,
    output logic       o_branch,
    output logic       o_jump,
    output logic       o_jr,
    output logic       o_jal,
    output logic       o_sign,
    output logic [2:0] o_lshb,
    output logic       o_hilowrite,
    output logic       o_hilotoreg,
    output logic       o_exc,
    output logic [1:0] o_exc_code,
    output logic       o_busy_mdu
);

    localparam logic [5:0] OP_R   = 6'd0,  OP_J    = 6'd2,  OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ = 6'd4,  OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8, OP_ADDIU = 6'd9, OP_SLTI = 6'd10, OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI = 6'd12, OP_ORI = 6'd13, OP_XORI = 6'd14, OP_LUI = 6'd15;
    localparam logic [5:0] OP_LB  = 6'd32, OP_LH   = 6'd33, OP_LW   = 6'd35;
    localparam logic [5:0] OP_LBU = 6'd36, OP_LHU  = 6'd37;
    localparam logic [5:0] OP_SB  = 6'd40, OP_SH   = 6'd41, OP_SW   = 6'd43;

    localparam logic [5:0] FN_JR   = 6'b001000, FN_JALR = 6'b001001;
    localparam logic [5:0] FN_MFHI = 6'b010000, FN_MTHI = 6'b010001;
    localparam logic [5:0] FN_MFLO = 6'b010010, FN_MTLO = 6'b010011;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MDU, S_TRAP
    } state_t;

    state_t          r_state;
    logic [5:0]      r_op;
    logic [5:0]      r_funct;
    logic [1:0]      r_addr_lo;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_exc_code;

    function automatic logic f_legal(input logic [5:0] op);
        return op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                          OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
                          OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic f_mdu(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_R) && (fn[5:2] == 4'b0110);
    endfunction

    logic w_rtype, w_load, w_store, w_imm, w_zext, w_br, w_j, w_jal, w_jr, w_jalr;
    logic w_mf, w_mt, w_half, w_word, w_misalign, w_mdu_last;
    logic [3:0] w_lanes;
    logic [2:0] w_lshb;

    assign w_rtype  = (r_op == OP_R);
    assign w_load   = r_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    assign w_store  = r_op inside {OP_SB, OP_SH, OP_SW};
    assign w_imm    = (r_op[5:3] == 3'b001);
    assign w_zext   = r_op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    assign w_br     = (r_op == OP_BEQ) || (r_op == OP_BNE);
    assign w_j      = (r_op == OP_J);
    assign w_jal    = (r_op == OP_JAL);
    assign w_jr     = w_rtype && (r_funct == FN_JR);
    assign w_jalr   = w_rtype && (r_funct == FN_JALR);
    assign w_mf     = w_rtype && ((r_funct == FN_MFHI) || (r_funct == FN_MFLO));
    assign w_mt     = w_rtype && ((r_funct == FN_MTHI) || (r_funct == FN_MTLO));

    // Access size is encoded in op[1:0] for every load/store: 00 byte, 01 half, 11 word.
    assign w_half     = (r_op[1:0] == 2'b01);
    assign w_word     = (r_op[1:0] == 2'b11);
    assign w_misalign = (w_half && i_addr_lo[0]) || (w_word && (i_addr_lo != 2'b00));
    assign w_mdu_last = (r_cnt == (r_funct[1] ? DIV_LAST : MULT_LAST));

    always_comb begin
        w_lanes = 4'b1111;
        if (r_op[1:0] == 2'b00)
            w_lanes = BIG_ENDIAN ? (4'b1000 >> r_addr_lo) : (4'b0001 << r_addr_lo);
        else if (r_op[1:0] == 2'b01)
            w_lanes = (r_addr_lo[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
    end

    always_comb begin
        case (r_op)
            OP_LB:   w_lshb = 3'b000;
            OP_LBU:  w_lshb = 3'b001;
            OP_LH:   w_lshb = 3'b010;
            OP_LHU:  w_lshb = 3'b011;
            OP_LW:   w_lshb = 3'b100;
            default: w_lshb = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_op       <= '0;
            r_funct    <= '0;
            r_addr_lo  <= '0;
            r_cnt      <= '0;
            r_exc_code <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (i_mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op    <= i_op;
                    r_funct <= i_funct;
                    if (!f_legal(i_op)) begin
                        r_exc_code <= 2'b01;
                        r_state    <= S_TRAP;
                    end else if (f_mdu(i_op, i_funct)) begin
                        r_cnt   <= '0;
                        r_state <= S_MDU;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_addr_lo <= i_addr_lo;
                    if (w_br || w_j || w_jal || w_jr || w_jalr) begin
                        r_state <= S_FETCH;
                    end else if (w_load || w_store) begin
                        if (w_misalign) begin
                            r_exc_code <= w_load ? 2'b10 : 2'b11;
                            r_state    <= S_TRAP;
                        end else begin
                            r_state <= S_MEM;
                        end
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: if (i_mem_ready) r_state <= w_load ? S_WB : S_FETCH;
                S_WB: r_state <= S_FETCH;
                S_MDU: begin
                    if (w_mdu_last) begin
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TRAP: r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded from state and the latched instruction; reset forces them all low.
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 4'b0000;
        o_ir_we     = 1'b0;
        o_pc_we     = 1'b0;
        o_regwrite  = 1'b0;
        o_regdst    = 1'b0;
        o_alusrc    = 1'b0;
        o_memtoreg  = 1'b0;
        o_branch    = 1'b0;
        o_jump      = 1'b0;
        o_jr        = 1'b0;
        o_jal       = 1'b0;
        o_sign      = 1'b0;
        o_lshb      = 3'b000;
        o_hilowrite = 1'b0;
        o_hilotoreg = 1'b0;
        o_exc       = 1'b0;
        o_exc_code  = 2'b00;
        o_busy_mdu  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    o_ir_we   = i_mem_ready;
                    o_pc_we   = i_mem_ready;
                end
                S_EXEC: begin
                    o_regdst   = w_rtype;
                    o_alusrc   = w_load || w_store || w_imm;
                    o_sign     = (w_load || w_store || w_imm) && !w_zext;
                    o_branch   = w_br;
                    o_jump     = w_j || w_jal;
                    o_jal      = w_jal;
                    o_jr       = w_jr || w_jalr;
                    o_pc_we    = w_j || w_jal || w_jr || w_jalr;
                    o_regwrite = w_jal || w_jalr;
                end
                S_MEM: begin
                    o_mem_req = 1'b1;
                    o_mem_we  = w_store ? w_lanes : 4'b0000;
                    o_lshb    = w_load ? w_lshb : 3'b000;
                end
                S_WB: begin
                    o_regwrite  = !w_mt;
                    o_regdst    = w_rtype && !w_mt;
                    o_memtoreg  = w_load;
                    o_lshb      = w_load ? w_lshb : 3'b000;
                    o_hilotoreg = w_mf;
                    o_hilowrite = w_mt;
                end
                S_MDU: begin
                    o_busy_mdu  = 1'b1;
                    o_hilowrite = w_mdu_last;
                end
                S_TRAP: begin
                    o_exc      = 1'b1;
                    o_exc_code = r_exc_code;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle comparison of two instances (little and
// big endian) against an instruction-level sequence model, plus summary vectors.
module tb_multicycle_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    localparam logic [5:0] R = 6'd0, J = 6'd2, JAL = 6'd3, BEQ = 6'd4, BNE = 6'd5;
    localparam logic [5:0] ADDI = 6'd8, ADDIU = 6'd9, SLTI = 6'd10, SLTIU = 6'd11;
    localparam logic [5:0] ANDI = 6'd12, ORI = 6'd13, XORI = 6'd14, LUI = 6'd15;
    localparam logic [5:0] LB = 6'd32, LH = 6'd33, LW = 6'd35, LBU = 6'd36, LHU = 6'd37;
    localparam logic [5:0] SB = 6'd40, SH = 6'd41, SW = 6'd43;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_SLT = 6'b101010, F_JR = 6'b001000, F_JALR = 6'b001001;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;

    typedef struct packed {
        logic       mem_req;
        logic [3:0] mem_we;
        logic       ir_we, pc_we, regwrite, regdst, alusrc, memtoreg;
        logic       branch, jump, jr, jal, sign;
        logic [2:0] lshb;
        logic       hilowrite, hilotoreg, exc;
        logic [1:0] exc_code;
        logic       busy_mdu;
    } outs_t;

    typedef struct {
        logic [5:0] op, fn;
        logic [1:0] a;
        int         fw, mw;
        int         e_req, e_busy, e_hlw, e_rw;
        logic [3:0] e_we;
        logic [1:0] e_code;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] i_op = '0, i_funct = '0;
    logic [1:0] i_addr_lo = '0;
    logic i_mem_ready = 1'b0;

    always #5 clk = ~clk;

    logic       req_a, irw_a, pcw_a, rw_a, rd_a, as_a, m2r_a, br_a, jmp_a, jr_a, jal_a, sg_a;
    logic       hlw_a, hlt_a, exc_a, bsy_a;
    logic [3:0] we_a;
    logic [2:0] lshb_a;
    logic [1:0] code_a;
    logic       req_b, irw_b, pcw_b, rw_b, rd_b, as_b, m2r_b, br_b, jmp_b, jr_b, jal_b, sg_b;
    logic       hlw_b, hlt_b, exc_b, bsy_b;
    logic [3:0] we_b;
    logic [2:0] lshb_b;
    logic [1:0] code_b;
    outs_t g_a, g_b;

    assign g_a = {req_a, we_a, irw_a, pcw_a, rw_a, rd_a, as_a, m2r_a, br_a, jmp_a, jr_a, jal_a,
                  sg_a, lshb_a, hlw_a, hlt_a, exc_a, code_a, bsy_a};
    assign g_b = {req_b, we_b, irw_b, pcw_b, rw_b, rd_b, as_b, m2r_b, br_b, jmp_b, jr_b, jal_b,
                  sg_b, lshb_b, hlw_b, hlt_b, exc_b, code_b, bsy_b};

    multicycle_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .i_op(i_op), .i_funct(i_funct), .i_addr_lo(i_addr_lo),
        .i_mem_ready(i_mem_ready), .o_mem_req(req_a), .o_mem_we(we_a), .o_ir_we(irw_a),
        .o_pc_we(pcw_a), .o_regwrite(rw_a), .o_regdst(rd_a), .o_alusrc(as_a),
        .o_memtoreg(m2r_a), .o_branch(br_a), .o_jump(jmp_a), .o_jr(jr_a), .o_jal(jal_a),
        .o_sign(sg_a), .o_lshb(lshb_a), .o_hilowrite(hlw_a), .o_hilotoreg(hlt_a),
        .o_exc(exc_a), .o_exc_code(code_a), .o_busy_mdu(bsy_a));

    multicycle_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .i_op(i_op), .i_funct(i_funct), .i_addr_lo(i_addr_lo),
        .i_mem_ready(i_mem_ready), .o_mem_req(req_b), .o_mem_we(we_b), .o_ir_we(irw_b),
        .o_pc_we(pcw_b), .o_regwrite(rw_b), .o_regdst(rd_b), .o_alusrc(as_b),
        .o_memtoreg(m2r_b), .o_branch(br_b), .o_jump(jmp_b), .o_jr(jr_b), .o_jal(jal_b),
        .o_sign(sg_b), .o_lshb(lshb_b), .o_hilowrite(hlw_b), .o_hilotoreg(hlt_b),
        .o_exc(exc_b), .o_exc_code(code_b), .o_busy_mdu(bsy_b));

    int n_checks = 0;
    int n_errors = 0;
    int c_req, c_busy, c_hlw, c_rw;
    logic [3:0] c_we;
    logic [1:0] c_code;

    outs_t q_exp[$];
    bit    q_rdy[$];
    bit    trap_end;

    task automatic check_o(input string nm, input int cyc, input outs_t got, input outs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic check_i(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] mirror(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic int acc_bytes(input logic [5:0] op);
        if (op inside {LB, LBU, SB}) return 1;
        if (op inside {LH, LHU, SH}) return 2;
        return 4;
    endfunction

    function automatic logic [2:0] load_code(input logic [5:0] op);
        case (op)
            LBU: return 3'd1;
            LH:  return 3'd2;
            LHU: return 3'd3;
            LW:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic push(input outs_t o, input bit r);
        q_exp.push_back(o);
        q_rdy.push_back(r);
    endtask

    task automatic add_trap(input logic [1:0] code);
        outs_t o;
        o = '0;
        o.exc = 1'b1;
        o.exc_code = code;
        repeat (3) push(o, 1'($urandom_range(0, 1)));
        trap_end = 1'b1;
    endtask

    // Expected cycle-by-cycle outputs of one instruction, derived from its phases.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] a,
                         input int fw, input int mw);
        outs_t o;
        bit rt, ld, st, imm, mt;
        int nb, nc;
        q_exp.delete();
        q_rdy.delete();
        trap_end = 1'b0;
        o = '0;
        o.mem_req = 1'b1;
        repeat (fw) push(o, 1'b0);
        o.ir_we = 1'b1;
        o.pc_we = 1'b1;
        push(o, 1'b1);
        push('0, 1'($urandom_range(0, 1)));
        if (!(op inside {R, J, JAL, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI,
                         LB, LH, LW, LBU, LHU, SB, SH, SW})) begin
            add_trap(2'b01);
            return;
        end
        rt = (op == R);
        if (rt && (fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU})) begin
            nc = (fn inside {F_DIV, F_DIVU}) ? DIV_N : MULT_N;
            for (int k = 0; k < nc; k++) begin
                o = '0;
                o.busy_mdu = 1'b1;
                o.hilowrite = (k == nc - 1);
                push(o, 1'($urandom_range(0, 1)));
            end
            return;
        end
        ld  = op inside {LB, LBU, LH, LHU, LW};
        st  = op inside {SB, SH, SW};
        imm = op inside {ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI};
        mt  = rt && (fn inside {F_MTHI, F_MTLO});
        o = '0;
        o.regdst = rt;
        o.alusrc = ld || st || imm;
        o.sign   = (ld || st || imm) && !(op inside {ANDI, ORI, XORI, LUI});
        o.branch = op inside {BEQ, BNE};
        if (op == J) begin o.jump = 1'b1; o.pc_we = 1'b1; end
        if (op == JAL) begin o.jump = 1'b1; o.jal = 1'b1; o.pc_we = 1'b1; o.regwrite = 1'b1; end
        if (rt && fn == F_JR) begin o.jr = 1'b1; o.pc_we = 1'b1; end
        if (rt && fn == F_JALR) begin o.jr = 1'b1; o.pc_we = 1'b1; o.regwrite = 1'b1; end
        push(o, 1'($urandom_range(0, 1)));
        if (o.branch || o.jump || o.jr) return;
        if (ld || st) begin
            nb = acc_bytes(op);
            if (int'(a) % nb != 0) begin
                add_trap(ld ? 2'b10 : 2'b11);
                return;
            end
            o = '0;
            o.mem_req = 1'b1;
            if (st) o.mem_we = 4'(((1 << nb) - 1) << int'(a));
            if (ld) o.lshb = load_code(op);
            repeat (mw) push(o, 1'b0);
            push(o, 1'b1);
            if (st) return;
        end
        o = '0;
        o.regwrite  = !mt;
        o.regdst    = rt && !mt;
        o.memtoreg  = ld;
        o.lshb      = ld ? load_code(op) : 3'd0;
        o.hilotoreg = rt && (fn inside {F_MFHI, F_MFLO});
        o.hilowrite = mt;
        push(o, 1'($urandom_range(0, 1)));
    endtask

    task automatic reset_seq();
        outs_t o;
        @(negedge clk);
        rst = 1'b1;
        i_mem_ready = 1'($urandom_range(0, 1));
        #1;
        check_o("rst_le", 0, g_a, '0);
        check_o("rst_be", 0, g_b, '0);
        @(negedge clk);
        rst = 1'b0;
        i_mem_ready = 1'b0;
        #1;
        o = '0;
        o.mem_req = 1'b1;
        check_o("post_rst_fetch", 0, g_a, o);
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] a,
                       input int fw, input int mw, input int abort_at);
        outs_t eb;
        build(op, fn, a, fw, mw);
        c_req = 0; c_busy = 0; c_hlw = 0; c_rw = 0; c_we = '0; c_code = '0;
        for (int k = 0; k < q_exp.size(); k++) begin
            if (k == abort_at) begin
                reset_seq();
                return;
            end
            @(negedge clk);
            i_op = op;
            i_funct = fn;
            i_addr_lo = a;
            i_mem_ready = q_rdy[k];
            #1;
            eb = q_exp[k];
            eb.mem_we = mirror(q_exp[k].mem_we);
            check_o("cyc_le", k, g_a, q_exp[k]);
            check_o("cyc_be", k, g_b, eb);
            c_req  += int'(g_a.mem_req);
            c_busy += int'(g_a.busy_mdu);
            c_hlw  += int'(g_a.hilowrite);
            c_rw   += int'(g_a.regwrite);
            c_we   |= g_a.mem_we;
            c_code |= g_a.exc_code;
        end
        if (trap_end) reset_seq();
    endtask

    vec_t tbl[$];
    logic [5:0] legal_ops[21] = '{R, J, JAL, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI,
                                  XORI, LUI, LB, LH, LW, LBU, LHU, SB, SH, SW};
    logic [5:0] r_fns[14] = '{F_ADD, F_SUB, F_AND, F_SLT, F_JR, F_JALR, F_MFHI, F_MTHI,
                              F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [5:0] op, fn;
        int abort_at;

        //         op    fn       a   fw mw req busy hlw rw  we       code
        tbl.push_back('{R,   F_ADD,  2'd0, 0, 0, 1, 0,  0, 1, 4'b0000, 2'b00});
        tbl.push_back('{LW,  6'd0,   2'd0, 0, 3, 5, 0,  0, 1, 4'b0000, 2'b00});
        tbl.push_back('{SB,  6'd0,   2'd2, 1, 0, 3, 0,  0, 0, 4'b0100, 2'b00});
        tbl.push_back('{SH,  6'd0,   2'd2, 0, 2, 4, 0,  0, 0, 4'b1100, 2'b00});
        tbl.push_back('{SW,  6'd0,   2'd0, 2, 1, 5, 0,  0, 0, 4'b1111, 2'b00});
        tbl.push_back('{R,   F_DIV,  2'd0, 0, 0, 1, 32, 1, 0, 4'b0000, 2'b00});
        tbl.push_back('{R,   F_MULT, 2'd0, 1, 0, 2, 4,  1, 0, 4'b0000, 2'b00});
        tbl.push_back('{R,   F_DIVU, 2'd1, 0, 0, 1, 32, 1, 0, 4'b0000, 2'b00});
        tbl.push_back('{LH,  6'd0,   2'd1, 0, 0, 1, 0,  0, 0, 4'b0000, 2'b10});
        tbl.push_back('{6'd63, 6'd0, 2'd0, 0, 0, 1, 0,  0, 0, 4'b0000, 2'b01});
        tbl.push_back('{SW,  6'd0,   2'd2, 0, 0, 1, 0,  0, 0, 4'b0000, 2'b11});
        tbl.push_back('{JAL, 6'd0,   2'd0, 0, 0, 1, 0,  0, 1, 4'b0000, 2'b00});
        tbl.push_back('{R,   F_MTHI, 2'd0, 0, 0, 1, 0,  1, 0, 4'b0000, 2'b00});
        tbl.push_back('{R,   F_MFLO, 2'd0, 0, 0, 1, 0,  0, 1, 4'b0000, 2'b00});
        tbl.push_back('{BEQ, 6'd0,   2'd0, 0, 0, 1, 0,  0, 0, 4'b0000, 2'b00});
        tbl.push_back('{LBU, 6'd0,   2'd3, 0, 1, 3, 0,  0, 1, 4'b0000, 2'b00});
        tbl.push_back('{R,   F_JALR, 2'd0, 0, 0, 1, 0,  0, 1, 4'b0000, 2'b00});
        tbl.push_back('{LW,  6'd0,   2'd2, 0, 0, 1, 0,  0, 0, 4'b0000, 2'b10});
        tbl.push_back('{LUI, 6'd0,   2'd0, 0, 0, 1, 0,  0, 1, 4'b0000, 2'b00});

        reset_seq();

        foreach (tbl[i]) begin
            run(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].fw, tbl[i].mw, -1);
            check_i($sformatf("v%0d_req", i), c_req, tbl[i].e_req);
            check_i($sformatf("v%0d_busy", i), c_busy, tbl[i].e_busy);
            check_i($sformatf("v%0d_hilowrite", i), c_hlw, tbl[i].e_hlw);
            check_i($sformatf("v%0d_regwrite", i), c_rw, tbl[i].e_rw);
            check_i($sformatf("v%0d_mem_we", i), int'(c_we), int'(tbl[i].e_we));
            check_i($sformatf("v%0d_exc_code", i), int'(c_code), int'(tbl[i].e_code));
        end

        // Reset in the middle of a divide, with the counter at 10.
        run(R, F_DIV, 2'd0, 0, 0, 12);
        check_i("abort_busy", c_busy, 10);
        check_i("abort_hilowrite", c_hlw, 0);
        run(R, F_ADD, 2'd0, 0, 0, -1);
        check_i("after_abort_regwrite", c_rw, 1);
        run(R, F_MULTU, 2'd0, 0, 0, 4);
        check_i("abort_mult_busy", c_busy, 2);
        run(SB, 6'd0, 2'd3, 0, 0, -1);
        check_i("sb3_we", int'(c_we), 8);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 20)];
            if (op == R && $urandom_range(0, 3) != 0) fn = r_fns[$urandom_range(0, 13)];
            else fn = 6'($urandom);
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1;
            run(op, fn, 2'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                abort_at);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
